exec_sequencer: RTL and testbench

Multi-cycle execution controller for the pico-MIPS core. Sits between the combinational instruction decoder and the PC/register file/multiplier/IO datapath. Passes single-cycle instructions straight through. Stalls the PC and gates register writes for three cases:
- MULT, which runs an iterative multiplier for a fixed cycle count;
- STIN, which waits for an input handshake;
- LOUT, which waits for an output handshake.

---
 rtl/exec_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_exec_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - multi-cycle execution controller for the pico-MIPS core
//
// Passes single-cycle instructions straight through. Stalls the PC and gates
// register writes while a MULT runs, while STIN waits for input data, and
// while LOUT waits for the sink.
// Optional feature macro: IO_TIMEOUT_EN bounds IN/OUT waits to IO_TIMEOUT cycles.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   dec_reg_write       decoder register write request
//   dec_pc_rel_branch   decoder relative branch (already ZF-qualified)
//   dec_mult            MULT opcode
//   dec_read_in         STIN opcode
//   dec_write_out       LOUT opcode
//   in_valid            external input data valid
//   out_ready           external sink ready
//   pc_en               PC advances this cycle
//   branch_en           PC takes the relative branch (only with pc_en)
//   reg_we              register file write enable
//   mult_start          one-cycle multiplier start pulse
//   in_ack              input data consumed this cycle
//   out_valid           output data valid towards the sink
//   busy                controller is not in EXEC
//   timeout             one-cycle pulse when an IO wait is aborted

module exec_sequencer #(
  parameter int MULT_CYCLES = 8,
  parameter int IO_TIMEOUT  = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic dec_reg_write,
  input  logic dec_pc_rel_branch,
  input  logic dec_mult,
  input  logic dec_read_in,
  input  logic dec_write_out,
  input  logic in_valid,
  input  logic out_ready,
  output logic pc_en,
  output logic branch_en,
  output logic reg_we,
  output logic mult_start,
  output logic in_ack,
  output logic out_valid,
  output logic busy,
  output logic timeout
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 255) begin : g_bad_mult_cycles
    $error("exec_sequencer: MULT_CYCLES out of range 1..255");
  end
  if (IO_TIMEOUT < 1) begin : g_bad_io_timeout
    $error("exec_sequencer: IO_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    EXEC      = 2'd0,
    MULT_WAIT = 2'd1,
    IN_WAIT   = 2'd2,
    OUT_WAIT  = 2'd3
  } state_t;

  localparam int CW = $clog2(MULT_CYCLES + 1);
  // The decode cycle counts as the first multiplier cycle, so load one less.
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] mult_cnt;
  logic          io_expired;

`ifdef IO_TIMEOUT_EN
  localparam int TW = $clog2(IO_TIMEOUT + 1);
  // io_cnt holds the number of completed wait cycles, so the IO_TIMEOUT-th
  // wait cycle is the one where it equals IO_TIMEOUT-1.
  localparam logic [TW-1:0] IO_LAST = TW'(IO_TIMEOUT - 1);

  logic [TW-1:0] io_cnt;

  assign io_expired = (io_cnt == IO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      io_cnt <= '0;
    end else if (state == IN_WAIT || state == OUT_WAIT) begin
      io_cnt <= io_cnt + 1'b1;
    end else begin
      // Held at zero in EXEC/MULT_WAIT so every wait starts from a clean count.
      io_cnt <= '0;
    end
  end
`else
  assign io_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EXEC;
      mult_cnt <= '0;
    end else begin
      case (state)
        EXEC: begin
          if (dec_mult) begin
            mult_cnt <= MULT_LOAD;
            state    <= MULT_WAIT;
          end else if (dec_read_in) begin
            if (!in_valid) state <= IN_WAIT;
          end else if (dec_write_out) begin
            if (!out_ready) state <= OUT_WAIT;
          end
        end
        MULT_WAIT: begin
          if (mult_cnt == '0) state <= EXEC;
          else                mult_cnt <= mult_cnt - 1'b1;
        end
        IN_WAIT: begin
          if (in_valid || io_expired) state <= EXEC;
        end
        OUT_WAIT: begin
          if (out_ready || io_expired) state <= EXEC;
        end
        default: state <= EXEC;
      endcase
    end
  end

  // Mealy outputs; reset overrides everything so nothing leaks during reset.
  always_comb begin
    pc_en      = 1'b0;
    branch_en  = 1'b0;
    reg_we     = 1'b0;
    mult_start = 1'b0;
    in_ack     = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    timeout    = 1'b0;
    if (!reset) begin
      case (state)
        EXEC: begin
          if (dec_mult) begin
            mult_start = 1'b1;
          end else if (dec_read_in) begin
            if (in_valid) begin
              in_ack = 1'b1;
              reg_we = 1'b1;
              pc_en  = 1'b1;
            end
          end else if (dec_write_out) begin
            out_valid = 1'b1;
            pc_en     = out_ready;
          end else begin
            pc_en     = 1'b1;
            reg_we    = dec_reg_write;
            branch_en = dec_pc_rel_branch;
          end
        end
        MULT_WAIT: begin
          busy = 1'b1;
          if (mult_cnt == '0) begin
            reg_we = 1'b1;
            pc_en  = 1'b1;
          end
        end
        IN_WAIT: begin
          busy = 1'b1;
          if (in_valid) begin
            in_ack = 1'b1;
            reg_we = 1'b1;
            pc_en  = 1'b1;
          end else if (io_expired) begin
            timeout = 1'b1;
            pc_en   = 1'b1;
          end
        end
        OUT_WAIT: begin
          busy = 1'b1;
          // A handshake on the limit cycle wins over the timeout.
          if (out_ready) begin
            out_valid = 1'b1;
            pc_en     = 1'b1;
          end else if (io_expired) begin
            timeout = 1'b1;
            pc_en   = 1'b1;
          end else begin
            out_valid = 1'b1;
          end
        end
        default: busy = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer

module tb_exec_sequencer;

  localparam int MC  = 8;
  localparam int IOT = 10;

  logic clk = 1'b0;
  logic reset, dec_reg_write, dec_pc_rel_branch, dec_mult, dec_read_in, dec_write_out;
  logic in_valid, out_ready;
  logic pc_en, branch_en, reg_we, mult_start, in_ack, out_valid, busy, timeout;

  exec_sequencer #(.MULT_CYCLES(MC), .IO_TIMEOUT(IOT)) dut (
    .clk(clk), .reset(reset),
    .dec_reg_write(dec_reg_write), .dec_pc_rel_branch(dec_pc_rel_branch),
    .dec_mult(dec_mult), .dec_read_in(dec_read_in), .dec_write_out(dec_write_out),
    .in_valid(in_valid), .out_ready(out_ready),
    .pc_en(pc_en), .branch_en(branch_en), .reg_we(reg_we), .mult_start(mult_start),
    .in_ack(in_ack), .out_valid(out_valid), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which multi-cycle operation is outstanding (0 none,
  // 1 mult, 2 input wait, 3 output wait) and how many cycles since decode.
  int m_op = 0;
  int m_el = 0;

  logic s_pc, s_br, s_we, s_ms, s_ack, s_ov, s_busy, s_to;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic br, input logic m,
                       input logic ri, input logic wo, input logic iv, input logic ordy);
    reset = r; dec_reg_write = w; dec_pc_rel_branch = br; dec_mult = m;
    dec_read_in = ri; dec_write_out = wo; in_valid = iv; out_ready = ordy;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step(input string tag);
    logic e_pc, e_br, e_we, e_ms, e_ack, e_ov, e_busy, e_to;
    int n_op, n_el;
    #3;
    {e_pc, e_br, e_we, e_ms, e_ack, e_ov, e_busy, e_to} = '0;
    n_op = m_op;
    n_el = m_el + 1;
    if (reset) begin
      n_op = 0;
    end else if (m_op == 0) begin
      if (dec_mult) begin
        e_ms = 1; n_op = 1; n_el = 1;
      end else if (dec_read_in) begin
        if (in_valid) begin e_ack = 1; e_we = 1; e_pc = 1; end
        else begin n_op = 2; n_el = 1; end
      end else if (dec_write_out) begin
        e_ov = 1;
        if (out_ready) e_pc = 1;
        else begin n_op = 3; n_el = 1; end
      end else begin
        e_pc = 1; e_we = dec_reg_write; e_br = dec_pc_rel_branch;
      end
    end else begin
      e_busy = 1;
      if (m_op == 1) begin
        if (m_el == MC) begin e_we = 1; e_pc = 1; n_op = 0; end
      end else if (m_op == 2) begin
        if (in_valid) begin e_ack = 1; e_we = 1; e_pc = 1; n_op = 0; end
`ifdef IO_TIMEOUT_EN
        else if (m_el == IOT) begin e_to = 1; e_pc = 1; n_op = 0; end
`endif
      end else begin
        if (out_ready) begin e_ov = 1; e_pc = 1; n_op = 0; end
`ifdef IO_TIMEOUT_EN
        else if (m_el == IOT) begin e_to = 1; e_pc = 1; n_op = 0; end
`endif
        else e_ov = 1;
      end
    end
    s_pc = pc_en; s_br = branch_en; s_we = reg_we; s_ms = mult_start;
    s_ack = in_ack; s_ov = out_valid; s_busy = busy; s_to = timeout;
    chk({tag, ".pc_en"}, s_pc, e_pc);
    chk({tag, ".branch_en"}, s_br, e_br);
    chk({tag, ".reg_we"}, s_we, e_we);
    chk({tag, ".mult_start"}, s_ms, e_ms);
    chk({tag, ".in_ack"}, s_ack, e_ack);
    chk({tag, ".out_valid"}, s_ov, e_ov);
    chk({tag, ".busy"}, s_busy, e_busy);
    chk({tag, ".timeout"}, s_to, e_to);
    m_op = n_op;
    m_el = n_el;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic saw_we;

    // Reset: every output forced low even with decoder flags set.
    for (int c = 0; c < 2; c++) begin
      drive(1, 1, 1, c[0], 1, 1, 1, 1);
      step("reset");
      chk("reset.all_zero", |{s_pc, s_br, s_we, s_ms, s_ack, s_ov, s_busy, s_to}, 1'b0);
    end

    // Plain instruction passes straight through.
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    step("plain");
    chk("plain.pc_en", s_pc, 1'b1);
    chk("plain.reg_we", s_we, 1'b1);
    chk("plain.branch_en", s_br, 1'b1);
    chk("plain.busy", s_busy, 1'b0);

    // MULT: start pulse, MC-1 stall cycles, completion on cycle MC.
    for (int c = 0; c <= MC + 1; c++) begin
      drive(0, 1, 0, (c <= MC), 0, 0, 0, 0);
      step("mult");
      if (c == 0) chk("mult.start_c0", s_ms, 1'b1);
      if (c >= 1 && c < MC) begin
        chk("mult.stall_pc", s_pc, 1'b0);
        chk("mult.stall_we", s_we, 1'b0);
        chk("mult.stall_busy", s_busy, 1'b1);
      end
      if (c == MC) begin
        chk("mult.done_we", s_we, 1'b1);
        chk("mult.done_pc", s_pc, 1'b1);
      end
      if (c == MC + 1) chk("mult.after_busy", s_busy, 1'b0);
    end

    // STIN with in_valid low for 3 cycles, then high.
    for (int c = 0; c <= 3; c++) begin
      drive(0, 1, 0, 0, 1, 0, (c == 3), 0);
      step("stin_wait");
      if (c >= 1) chk("stin_wait.busy", s_busy, 1'b1);
      chk("stin_wait.ack", s_ack, (c == 3));
      chk("stin_wait.pc", s_pc, (c == 3));
    end

    // STIN with data already valid: no stall.
    drive(0, 1, 0, 0, 1, 0, 1, 0);
    step("stin_fast");
    chk("stin_fast.ack", s_ack, 1'b1);
    chk("stin_fast.we", s_we, 1'b1);
    chk("stin_fast.busy", s_busy, 1'b0);

    // LOUT with the sink stalled for 4 cycles.
    for (int c = 0; c <= 5; c++) begin
      drive(0, 0, 0, 0, 0, (c <= 4), 0, (c == 4));
      step("lout");
      if (c <= 4) chk("lout.out_valid", s_ov, 1'b1);
      if (c <= 4) chk("lout.pc_en", s_pc, (c == 4));
      if (c == 5) chk("lout.after_busy", s_busy, 1'b0);
    end

    // Reset in the middle of a MULT: no write ever reaches the register file.
    saw_we = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      drive((c == 4), (c == 5), 0, (c < 5), 0, 0, 0, 0);
      step("mult_abort");
      if (c < 5) saw_we |= s_we;
      if (c == 5) begin
        chk("mult_abort.no_we", saw_we, 1'b0);
        chk("mult_abort.busy", s_busy, 1'b0);
        chk("mult_abort.plain_we", s_we, 1'b1);
      end
    end

`ifdef IO_TIMEOUT_EN
    // STIN stuck: abort on the IOT-th wait cycle.
    for (int c = 0; c <= IOT; c++) begin
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      step("stin_to");
      chk("stin_to.timeout", s_to, (c == IOT));
      if (c == IOT) begin
        chk("stin_to.pc", s_pc, 1'b1);
        chk("stin_to.we", s_we, 1'b0);
      end
    end
    // Handshake on the limit cycle wins.
    for (int c = 0; c <= IOT; c++) begin
      drive(0, 1, 0, 0, 1, 0, (c == IOT), 0);
      step("stin_race");
      if (c == IOT) begin
        chk("stin_race.timeout", s_to, 1'b0);
        chk("stin_race.ack", s_ack, 1'b1);
      end
    end
`else
    // Without the bound the wait is indefinite.
    for (int c = 0; c <= 300; c++) begin
      drive(0, 1, 0, 0, 1, 0, (c == 300), 0);
      step("stin_long");
      if (c >= 1 && c < 300) chk("stin_long.busy", s_busy, 1'b1);
      chk("stin_long.timeout", s_to, 1'b0);
    end
`endif

    // Randomized instruction/handshake stream against the model.
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 79) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0));
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
